// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: default widths, bubble encoding, register-index
// field positions and the stage occupancy encoding.
package riscv_pipe_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready 2-entry skid buffer. Main entry drives the output, the
// skid entry catches the one beat accepted while the consumer stalls.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    stage_state_e state, state_nxt;
    logic [W-1:0] m_q, s_q;
    logic         rdy_q;
    logic         in_xfer, out_xfer;
    logic         load_m_in, load_m_s, load_s;

    // Registered ready, gated so nothing is taken while resetting or clearing.
    assign in_ready  = rdy_q & ~rst & ~clear;
    assign out_valid = (state != EMPTY);
    assign out_data  = m_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready & ~clear & ~rst;

    always_comb begin
        state_nxt = state;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = TWO;
                    load_s    = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_nxt = ONE;
                    load_m_s  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (clear) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (load_m_in)     m_q <= in_data;
        else if (load_m_s) m_q <= s_q;
        if (load_s)        s_q <= in_data;
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF->ID stage register: carries instruction and PC with valid/ready, kills
// held entries on flush, presents a NOP bubble when empty and slices reg indices.
module if_id_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              REG_IDX_W = REG_IDX_W_DEF,
    parameter logic [XLEN-1:0] NOP_INST  = riscv_pipe_pkg::NOP_INST,
    parameter bit              SKID      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_inst,
    output logic [XLEN-1:0]      out_pc,
    output logic [REG_IDX_W-1:0] rs1,
    output logic [REG_IDX_W-1:0] rs2,
    output logic [REG_IDX_W-1:0] rd
);

    localparam int W = 2 * XLEN;

    logic [W-1:0] in_data, held;
    logic         held_valid;

    assign in_data = {in_pc, in_inst};

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(.W(W)) u_buf (
                .clk       (clk),
                .rst       (rst),
                .clear     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (in_data),
                .out_valid (held_valid),
                .out_ready (out_ready),
                .out_data  (held)
            );
        end else begin : g_single
            stage_state_e state;
            logic [W-1:0] m_q;

            // Combinational ready: a consumed entry can be replaced in the same cycle.
            assign in_ready   = ((state == EMPTY) | out_ready) & ~rst & ~flush;
            assign held_valid = (state == ONE);
            assign held       = m_q;

            always_ff @(posedge clk) begin
                if (rst || flush)                 state <= EMPTY;
                else if (in_valid && in_ready)    state <= ONE;
                else if (out_ready)               state <= EMPTY;
            end

            always_ff @(posedge clk) begin
                if (in_valid && in_ready) m_q <= in_data;
            end
        end
    endgenerate

    assign out_valid = held_valid;
    assign out_inst  = held_valid ? held[XLEN-1:0] : NOP_INST;
    assign out_pc    = held_valid ? held[W-1:XLEN] : '0;

    assign rs1 = out_inst[RS1_LSB +: REG_IDX_W];
    assign rs2 = out_inst[RS2_LSB +: REG_IDX_W];
    assign rd  = out_inst[RD_LSB  +: REG_IDX_W];

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg (SKID=1 and SKID=0 instances) with a
// queue scoreboard per instance checking every decode-side transfer.
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, flush;
    logic        iv1, irdy1, ov1, ordy1;
    logic [31:0] ii1, ip1, oi1, op1;
    logic [4:0]  rs1_1, rs2_1, rd_1;
    logic        iv0, irdy0, ov0, ordy0;
    logic [31:0] ii0, ip0, oi0, op0;
    logic [4:0]  rs1_0, rs2_0, rd_0;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;

    logic [31:0] sv [4] = '{32'h0050_0113, 32'h0010_0093, 32'h4020_8033, 32'h0020_81B3};

    if_id_stage_reg #(.SKID(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(irdy1), .in_inst(ii1), .in_pc(ip1),
        .out_valid(ov1), .out_ready(ordy1), .out_inst(oi1), .out_pc(op1),
        .rs1(rs1_1), .rs2(rs2_1), .rd(rd_1)
    );

    if_id_stage_reg #(.SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(irdy0), .in_inst(ii0), .in_pc(ip0),
        .out_valid(ov0), .out_ready(ordy0), .out_inst(oi0), .out_pc(op0),
        .rs1(rs1_0), .rs2(rs2_0), .rd(rd_0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else passed++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected beats are queued on acceptance, popped on delivery.
    always @(negedge clk) begin
        if (rst || flush) begin
            q1.delete();
        end else begin
            if (ov1 && ordy1) begin
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL sb1_unexpected: got inst %h pc %h, required no output", oi1, op1);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_inst", oi1, e1.inst);
                    chk("sb1_pc", op1, e1.pc);
                end
            end
            if (iv1 && irdy1) q1.push_back('{ii1, ip1});
        end
    end

    always @(negedge clk) begin
        if (rst || flush) begin
            q0.delete();
        end else begin
            if (ov0 && ordy0) begin
                if (q0.size() == 0) begin
                    total++;
                    $display("FAIL sb0_unexpected: got inst %h pc %h, required no output", oi0, op0);
                end else begin
                    e0 = q0.pop_front();
                    chk("sb0_inst", oi0, e0.inst);
                    chk("sb0_pc", op0, e0.pc);
                end
            end
            if (iv0 && irdy0) q0.push_back('{ii0, ip0});
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        iv1 = 1'b1; ii1 = 32'h00A0_0093; ip1 = 32'h100; ordy1 = 1'b0;
        iv0 = 1'b0; ii0 = 32'h0; ip0 = 32'h0; ordy0 = 1'b0;

        // 1: reset
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", ov1, 0);
            chk("rst_out_inst", oi1, NOP);
            chk("rst_out_pc", op1, 0);
            chk("rst_in_ready", irdy1, 0);
            chk("rst_in_ready_s0", irdy0, 0);
            cyc();
        end
        rst = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", irdy1, 1);
        chk("post_rst_in_ready_s0", irdy0, 1);
        chk("post_rst_out_valid", ov1, 0);
        cyc();

        // 2: streaming at full rate
        ordy1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv1 = 1'b1; ii1 = sv[k]; ip1 = 32'(4 * k);
            @(negedge clk);
            chk("stream_in_ready", irdy1, 1);
            if (k > 0) begin
                chk("stream_valid", ov1, 1);
                chk("stream_inst", oi1, sv[k-1]);
            end
            cyc();
        end
        iv1 = 1'b0;
        @(negedge clk);
        chk("stream_last_inst", oi1, 32'h0020_81B3);
        chk("stream_last_pc", op1, 32'hC);
        chk("rs1", rs1_1, 1);
        chk("rs2", rs2_1, 2);
        chk("rd", rd_1, 3);
        cyc();
        @(negedge clk);
        chk("stream_drained_valid", ov1, 0);
        chk("stream_drained_inst", oi1, NOP);
        cyc();

        // 3: back-pressure fills the skid entry
        ordy1 = 1'b0; iv1 = 1'b1; ii1 = 32'hA000_0013; ip1 = 32'h20;
        @(negedge clk);
        chk("bp_a_ready", irdy1, 1);
        cyc();
        ii1 = 32'hB000_0013; ip1 = 32'h24;
        @(negedge clk);
        chk("bp_a_valid", ov1, 1);
        chk("bp_a_inst", oi1, 32'hA000_0013);
        chk("bp_b_ready", irdy1, 1);
        cyc();
        ii1 = 32'hC000_0013; ip1 = 32'h28;
        @(negedge clk);
        chk("bp_two_ready", irdy1, 0);
        chk("bp_two_inst", oi1, 32'hA000_0013);
        cyc();
        @(negedge clk);
        chk("bp_hold_ready", irdy1, 0);
        chk("bp_hold_inst", oi1, 32'hA000_0013);
        chk("bp_hold_pc", op1, 32'h20);
        cyc();
        ordy1 = 1'b1;
        @(negedge clk);
        chk("drain_a", oi1, 32'hA000_0013);
        cyc();
        @(negedge clk);
        chk("drain_b", oi1, 32'hB000_0013);
        chk("drain_b_ready", irdy1, 1);
        cyc();
        iv1 = 1'b0;
        @(negedge clk);
        chk("drain_c", oi1, 32'hC000_0013);
        chk("drain_c_pc", op1, 32'h28);
        cyc();
        @(negedge clk);
        chk("drain_empty", ov1, 0);
        cyc();

        // 4: flush while TWO
        ordy1 = 1'b0; iv1 = 1'b1; ii1 = 32'hA200_0013; ip1 = 32'h30;
        @(negedge clk);
        cyc();
        ii1 = 32'hB200_0013; ip1 = 32'h34;
        @(negedge clk);
        cyc();
        flush = 1'b1; ii1 = 32'hD000_0013; ip1 = 32'h38; ordy1 = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", irdy1, 0);
        cyc();
        flush = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        chk("flush_valid", ov1, 0);
        chk("flush_inst", oi1, NOP);
        chk("flush_pc", op1, 0);
        chk("flush_ready", irdy1, 1);
        cyc();
        @(negedge clk);
        chk("flush_stays_empty", ov1, 0);
        cyc();

        // 5: single-entry build
        ordy0 = 1'b0; iv0 = 1'b1; ii0 = 32'hE000_0013; ip0 = 32'h40;
        @(negedge clk);
        chk("s0_empty_ready", irdy0, 1);
        cyc();
        ii0 = 32'hF000_0013; ip0 = 32'h44;
        @(negedge clk);
        chk("s0_valid", ov0, 1);
        chk("s0_inst_e", oi0, 32'hE000_0013);
        chk("s0_full_ready", irdy0, 0);
        cyc();
        @(negedge clk);
        chk("s0_hold_ready", irdy0, 0);
        chk("s0_hold_inst", oi0, 32'hE000_0013);
        cyc();
        ordy0 = 1'b1;
        @(negedge clk);
        chk("s0_pass_ready", irdy0, 1);
        cyc();
        ii0 = 32'h6000_0013; ip0 = 32'h48;
        @(negedge clk);
        chk("s0_inst_f", oi0, 32'hF000_0013);
        chk("s0_replace_ready", irdy0, 1);
        cyc();
        iv0 = 1'b0;
        @(negedge clk);
        chk("s0_inst_g", oi0, 32'h6000_0013);
        cyc();
        @(negedge clk);
        chk("s0_empty", ov0, 0);
        cyc();

        // 6: rst and flush together mid-stream
        ordy1 = 1'b0; iv1 = 1'b1; ii1 = 32'h7000_0013; ip1 = 32'h50;
        @(negedge clk);
        cyc();
        rst = 1'b1; flush = 1'b1; ii1 = 32'h8000_0013; ip1 = 32'h54; ordy1 = 1'b1;
        @(negedge clk);
        chk("rstfl_in_ready", irdy1, 0);
        cyc();
        @(negedge clk);
        chk("rstfl_valid", ov1, 0);
        chk("rstfl_inst", oi1, NOP);
        chk("rstfl_pc", op1, 0);
        chk("rstfl_rd", rd_1, 0);
        chk("rstfl_rs1", rs1_1, 0);
        chk("rstfl_in_ready2", irdy1, 0);
        cyc();
        rst = 1'b0; flush = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        chk("rstfl_after_ready", irdy1, 1);
        chk("rstfl_after_valid", ov1, 0);
        cyc();
        @(negedge clk);
        chk("rstfl_idle_valid", ov1, 0);
        cyc();

        chk("sb1_drained", 64'(q1.size()), 0);
        chk("sb0_drained", 64'(q0.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
